// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - fifo pop port and output stream bundle for fifo_stream_reader
interface fifo_stream_reader_if #(
    parameter int DATA_W = 8
) ();
    logic              fifo_empty_i;
    logic              fifo_pop_o;
    logic [DATA_W-1:0] fifo_pop_data_i;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_last_o;
    logic              out_ready_i;

    modport master (
        input  fifo_empty_i,
        input  fifo_pop_data_i,
        input  out_ready_i,
        output fifo_pop_o,
        output out_valid_o,
        output out_data_o,
        output out_last_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_pop_data_i,
        output out_ready_i,
        input  fifo_pop_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - burst reader turning edge-triggered fifo pops into a valid/ready stream
// Optional FIFO_READER_PREFETCH_EN adds a second holding entry so pops overlap the output handshake.
module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    fifo_stream_reader_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_t;

    state_t             state;
    state_t             state_nx;
    logic [LEN_W-1:0]   pops_left;
    logic [LEN_W-1:0]   words_left;
    logic               pop_q;
    logic               done_q;
    logic [1:0]         cnt;
    logic [1:0]         cnt_nx;
    logic [DATA_W-1:0]  buf0;
`ifdef FIFO_READER_PREFETCH_EN
    logic [DATA_W-1:0]  buf1;
`endif
    logic               hs;
    logic               last_hs;
    logic               slot_ok;
    logic               issue_pop;
    logic               accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // HOLD means the head entry is valid; WAIT means the output is empty but a pop is in flight.
    always_comb begin
        hs      = (state == ST_HOLD) && bus.out_ready_i;
        last_hs = hs && (words_left == LEN_W'(1));
        accept  = (state == ST_IDLE) && start_i && (len_i != '0);
`ifdef FIFO_READER_PREFETCH_EN
        slot_ok = ((state == ST_REQ) || (state == ST_HOLD)) && (cnt != 2'd2);
`else
        slot_ok = (state == ST_REQ);
`endif
        issue_pop = slot_ok && !abort_i && !pop_q && (pops_left != '0) && !bus.fifo_empty_i;
        cnt_nx    = cnt + {1'b0, pop_q} - {1'b0, hs};
        state_nx  = state;
        if (state == ST_IDLE) begin
            if (accept) begin
                state_nx = ST_REQ;
            end
        end else if (abort_i || last_hs) begin
            state_nx = ST_IDLE;
        end else if (cnt_nx != 2'd0) begin
            state_nx = ST_HOLD;
        end else if (issue_pop) begin
            state_nx = ST_WAIT;
        end else begin
            state_nx = ST_REQ;
        end
    end

    always_comb begin
        busy_o          = (state != ST_IDLE);
        done_o          = done_q;
        bus.fifo_pop_o  = pop_q;
        bus.out_valid_o = (state == ST_HOLD);
        bus.out_last_o  = (state == ST_HOLD) && (words_left == LEN_W'(1));
        bus.out_data_o  = buf0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_q      <= 1'b0;
            done_q     <= 1'b0;
            cnt        <= 2'd0;
            pops_left  <= '0;
            words_left <= '0;
        end else if ((state != ST_IDLE) && abort_i) begin
            pop_q      <= 1'b0;
            done_q     <= 1'b0;
            cnt        <= 2'd0;
            pops_left  <= '0;
            words_left <= '0;
        end else if (accept) begin
            pop_q      <= 1'b0;
            done_q     <= 1'b0;
            cnt        <= 2'd0;
            pops_left  <= len_i;
            words_left <= len_i;
        end else begin
            pop_q  <= issue_pop;
            done_q <= last_hs;
            cnt    <= last_hs ? 2'd0 : cnt_nx;
            if (issue_pop) begin
                pops_left <= pops_left - LEN_W'(1);
            end
            if (hs) begin
                words_left <= words_left - LEN_W'(1);
            end
        end
    end

    // Pop data is captured on the edge that ends the pop pulse, while the fifo still shows that word.
`ifdef FIFO_READER_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            case ({hs, pop_q})
                2'b10: buf0 <= buf1;
                2'b01: begin
                    if (cnt == 2'd0) begin
                        buf0 <= bus.fifo_pop_data_i;
                    end else begin
                        buf1 <= bus.fifo_pop_data_i;
                    end
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        buf0 <= bus.fifo_pop_data_i;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= bus.fifo_pop_data_i;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            buf0 <= '0;
        end else if (pop_q) begin
            buf0 <= bus.fifo_pop_data_i;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed bench for fifo_stream_reader with a show-ahead fifo model
module tb_fifo_stream_reader;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic             abort_i;
    logic             busy_o;
    logic             done_o;

    fifo_stream_reader_if #(.DATA_W(DATA_W)) bus ();

    fifo_stream_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .len_i   (len_i),
        .abort_i (abort_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] fq[$];
    logic [7:0] rx[$];
    logic       rxl[$];
    int pops, underflows, adjacent, unstable, done_cnt, ticks, first_valid, last_hs_tick, pops_pre;
    bit prev_pop;

    function void refresh();
        bus.fifo_empty_i    = (fq.size() == 0);
        bus.fifo_pop_data_i = (fq.size() != 0) ? fq[0] : 8'h00;
    endfunction

    function void clear();
        rx.delete();
        rxl.delete();
        pops = 0; underflows = 0; adjacent = 0; unstable = 0;
        done_cnt = 0; ticks = 0; first_valid = 0; last_hs_tick = 0;
    endfunction

    function logic [7:0] word(input int i);
        logic [7:0] w;
        w = 8'hxx;
        if (i < rx.size()) w = rx[i];
        return w;
    endfunction

    function logic [7:0] last_bits();
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < rx.size() && i < 8; i++) b[i] = rxl[i];
        return b;
    endfunction

    task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task tick();
        bit p, h, hold;
        logic [7:0] d;
        logic l;
        p    = bus.fifo_pop_o;
        h    = bus.out_valid_o && bus.out_ready_i;
        hold = bus.out_valid_o && !bus.out_ready_i && !abort_i && !rst;
        d    = bus.out_data_o;
        l    = bus.out_last_o;
        @(posedge clk);
        #1;
        ticks++;
        if (p) begin
            pops++;
            if (prev_pop) adjacent++;
            if (fq.size() == 0) underflows++;
            else void'(fq.pop_front());
        end
        prev_pop = p;
        if (h) begin
            rx.push_back(d);
            rxl.push_back(l);
            last_hs_tick = ticks;
        end
        if (hold && (!bus.out_valid_o || bus.out_data_o !== d || bus.out_last_o !== l)) unstable++;
        if (done_o) done_cnt++;
        if (first_valid == 0 && bus.out_valid_o) first_valid = ticks;
        refresh();
    endtask

    task burst(input int len, input int budget, input bit toggle);
        start_i = 1'b1;
        len_i   = LEN_W'(len);
        tick();
        start_i = 1'b0;
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            if (toggle) bus.out_ready_i = ~bus.out_ready_i;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; len_i = '0;
        bus.out_ready_i = 1'b1;
        prev_pop = 1'b0;
        clear();
        refresh();
        tick();
        tick();
        check("reset_outputs", {busy_o, done_o, bus.fifo_pop_o, bus.out_valid_o, bus.out_last_o, bus.out_data_o}, 32'h0);
        rst = 1'b0;
        tick();

        // in-order burst of three
        clear();
        fq = '{8'h11, 8'h22, 8'h33};
        refresh();
        burst(3, 30, 1'b0);
        check("t1_count", rx.size(), 3);
        check("t1_w0", word(0), 8'h11);
        check("t1_w1", word(1), 8'h22);
        check("t1_w2", word(2), 8'h33);
        check("t1_last", last_bits(), 8'b100);
        check("t1_done", done_cnt, 1);
        check("t1_pops", pops, 3);
        check("t1_latency", first_valid, 3);
        check("t1_adjacent", adjacent, 0);
        check("t1_busy_after", busy_o, 1'b0);

        // empty fifo with late pushes
        clear();
        start_i = 1'b1; len_i = 8'd2;
        tick();
        start_i = 1'b0;
        pops_pre = -1;
        for (int i = 1; i <= 40 && done_cnt == 0; i++) begin
            if (i == 10) begin
                pops_pre = pops;
                fq.push_back(8'hA5);
            end
            if (i == 20) fq.push_back(8'h5A);
            refresh();
            tick();
        end
        check("t2_no_pop_while_empty", pops_pre, 0);
        check("t2_underflow", underflows, 0);
        check("t2_w0", word(0), 8'hA5);
        check("t2_w1", word(1), 8'h5A);
        check("t2_done", done_cnt, 1);

        // backpressure toggling every cycle
        clear();
        fq = '{8'h01, 8'h02, 8'h03, 8'h04};
        refresh();
        bus.out_ready_i = 1'b1;
        burst(4, 60, 1'b1);
        check("t3_count", rx.size(), 4);
        check("t3_words", {word(0), word(1), word(2), word(3)}, 32'h01020304);
        check("t3_last", last_bits(), 8'b1000);
        check("t3_stable", unstable, 0);
        check("t3_done", done_cnt, 1);

        // abort while word 2 is held
        clear();
        bus.out_ready_i = 1'b1;
        fq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        refresh();
        start_i = 1'b1; len_i = 8'd5;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 20 && rx.size() == 0; i++) tick();
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid_o; i++) tick();
        check("t4_held_word", bus.out_data_o, 8'h42);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t4_valid_after_abort", bus.out_valid_o, 1'b0);
        check("t4_busy_after_abort", busy_o, 1'b0);
        tick(); tick(); tick();
        check("t4_no_done", done_cnt, 0);
        check("t4_pops", pops, 2);
        bus.out_ready_i = 1'b1;
        clear();
        burst(1, 20, 1'b0);
        check("t4_restart_word", word(0), 8'h43);
        check("t4_restart_last", last_bits(), 8'b1);
        check("t4_restart_done", done_cnt, 1);

        // reset while the pop is in flight
        clear();
        fq.delete();
        fq.push_back(8'h77);
        refresh();
        start_i = 1'b1; len_i = 8'd1;
        tick();
        start_i = 1'b0;
        tick();
        check("t5_wait_pop", bus.fifo_pop_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_reset_outputs", {busy_o, done_o, bus.fifo_pop_o, bus.out_valid_o, bus.out_last_o, bus.out_data_o}, 32'h0);
        start_i = 1'b1; len_i = 8'd0;
        tick();
        start_i = 1'b0;
        check("t5_len0_busy", busy_o, 1'b0);
        tick(); tick(); tick();
        check("t5_len0_done", done_cnt, 0);
        check("t5_pops", pops, 1);
        check("t5_fifo_left", fq.size(), 0);

`ifdef FIFO_READER_PREFETCH_EN
        // sustained prefetch throughput
        clear();
        bus.out_ready_i = 1'b1;
        fq = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
        refresh();
        burst(8, 60, 1'b0);
        check("t6_count", rx.size(), 8);
        check("t6_words_lo", {word(0), word(1), word(2), word(3)}, 32'h80818283);
        check("t6_words_hi", {word(4), word(5), word(6), word(7)}, 32'h84858687);
        check("t6_last", last_bits(), 8'b1000_0000);
        check("t6_within_18", (last_hs_tick <= 18 && last_hs_tick > 0), 1'b1);
        check("t6_adjacent", adjacent, 0);
        check("t6_done", done_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
